// File: rtl/snn_frame_stats_pkg.sv
// Shared definitions for the SNN frame-statistics stage.
//  - Reference colours emitted by the upstream classifier.
//  - 2-bit pixel class encoding, which also indexes the counter arrays.
//  - Counting FSM state encoding.
//  - Packed video beat carried through the one-cycle pass-through register.
package snn_frame_stats_pkg;

   localparam logic [23:0] COL_BLUE   = 24'h0000FF;
   localparam logic [23:0] COL_YELLOW = 24'hFFFF00;
   localparam logic [23:0] COL_BLACK  = 24'h000000;

   typedef enum logic [1:0] {
      CLS_BLUE   = 2'd0,
      CLS_YELLOW = 2'd1,
      CLS_BLACK  = 2'd2,
      CLS_OTHER  = 2'd3
   } cls_e;

   typedef enum logic {
      S_SYNC  = 1'b0,
      S_COUNT = 1'b1
   } state_e;

   typedef struct packed {
      logic       vs;
      logic       hs;
      logic       de;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } video_t;

endpackage

// File: rtl/snn_frame_stats_if.sv
// Snapshot readout bus of snn_frame_stats.
//  stat_blue/yellow/black/other : per-class pixel counts of the last completed frame
//  stat_frame                   : index of the snapshotted frame
//  stat_valid / stat_ready      : valid/ready handshake, producer drives valid
//  stat_ovr                     : sticky flag, a snapshot was overwritten before acceptance
// master = producer (snn_frame_stats), slave = consumer.
interface snn_frame_stats_if #(
   parameter int CNT_W = 24,
   parameter int FRM_W = 16
);
   logic [CNT_W-1:0] stat_blue;
   logic [CNT_W-1:0] stat_yellow;
   logic [CNT_W-1:0] stat_black;
   logic [CNT_W-1:0] stat_other;
   logic [FRM_W-1:0] stat_frame;
   logic             stat_valid;
   logic             stat_ready;
   logic             stat_ovr;

   modport master (
      output stat_blue, stat_yellow, stat_black, stat_other,
      output stat_frame, stat_valid, stat_ovr,
      input  stat_ready
   );

   modport slave (
      input  stat_blue, stat_yellow, stat_black, stat_other,
      input  stat_frame, stat_valid, stat_ovr,
      output stat_ready
   );
endinterface

// File: rtl/snn_frame_stats_rgb_class_decode.sv
// Combinational pixel class decoder.
//  de      in  data enable; a pixel is only counted when set
//  r,g,b   in  classified pixel colour
//  cls     out class of the colour (blue/yellow/black/other)
//  hit     out pixel present this cycle
module snn_frame_stats_rgb_class_decode
   import snn_frame_stats_pkg::*;
(
   input  logic       de,
   input  logic [7:0] r,
   input  logic [7:0] g,
   input  logic [7:0] b,
   output cls_e       cls,
   output logic       hit
);

   always_comb begin
      cls = CLS_OTHER;
      if ({r, g, b} == COL_BLUE) begin
         cls = CLS_BLUE;
      end else if ({r, g, b} == COL_YELLOW) begin
         cls = CLS_YELLOW;
      end else if ({r, g, b} == COL_BLACK) begin
         cls = CLS_BLACK;
      end
      hit = de;
   end

endmodule

// File: rtl/snn_frame_stats.sv
// Per-frame class statistics for the SNN RGB classifier output.
//  clk, reset_n            clock and synchronous active-low reset
//  vs/hs/de/r/g/b _in      classified video from the classifier
//  vs/hs/de/r/g/b _out     same video delayed by one clock, unmodified
//  stat (master)           snapshot readout with valid/ready handshake
//  led                     {blue,yellow,black} one-hot dominant class of the last frame
// Counting starts at the first frame start after reset; each later frame start
// snapshots the finished frame's counts and restarts counting.
module snn_frame_stats
   import snn_frame_stats_pkg::*;
#(
   parameter int CNT_W = 24,
   parameter int FRM_W = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               vs_in,
   input  logic               hs_in,
   input  logic               de_in,
   input  logic [7:0]         r_in,
   input  logic [7:0]         g_in,
   input  logic [7:0]         b_in,
   output logic               vs_out,
   output logic               hs_out,
   output logic               de_out,
   output logic [7:0]         r_out,
   output logic [7:0]         g_out,
   output logic [7:0]         b_out,
   snn_frame_stats_if.master  stat,
   output logic [2:0]         led
);

   // counters saturate so an oversized frame reports full scale instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
   endfunction

   // ties go blue > yellow > black; an empty frame reports black
   function automatic logic [2:0] dominant(input logic [CNT_W-1:0] nb,
                                           input logic [CNT_W-1:0] ny,
                                           input logic [CNT_W-1:0] nk);
      if (nb == '0 && ny == '0 && nk == '0) return 3'b001;
      if (nb >= ny && nb >= nk)             return 3'b100;
      if (ny >= nk)                         return 3'b010;
      return 3'b001;
   endfunction

   video_t                  vid_d, vid_q;
   state_e                  state_d, state_q;
   logic [3:0][CNT_W-1:0]   cnt_d, cnt_q;
   logic [3:0][CNT_W-1:0]   snap_d, snap_q;
   logic [FRM_W-1:0]        frm_cnt_d, frm_cnt_q;
   logic [FRM_W-1:0]        frame_d, frame_q;
   logic                    valid_d, valid_q;
   logic                    ovr_d, ovr_q;
   logic [2:0]              led_d, led_q;

   cls_e                    pix_cls;
   logic                    pix_hit;
   logic                    fs;
   logic                    snap_now;

   snn_frame_stats_rgb_class_decode u_decode (
      .de  (de_in),
      .r   (r_in),
      .g   (g_in),
      .b   (b_in),
      .cls (pix_cls),
      .hit (pix_hit)
   );

   // Stage 0: frame-start detect, counting and snapshot next-state
   always_comb begin
      vid_d     = '{vs: vs_in, hs: hs_in, de: de_in, r: r_in, g: g_in, b: b_in};
      // registered vs doubles as the edge-detect history
      fs        = vs_in & ~vid_q.vs;
      state_d   = state_q;
      cnt_d     = cnt_q;
      snap_d    = snap_q;
      frm_cnt_d = frm_cnt_q;
      frame_d   = frame_q;
      valid_d   = valid_q;
      ovr_d     = ovr_q;
      led_d     = led_q;
      snap_now  = 1'b0;

      case (state_q)
         S_SYNC: begin
            if (fs) begin
               state_d = S_COUNT;
               cnt_d   = '0;
               if (pix_hit) cnt_d[pix_cls] = CNT_W'(1);
            end
         end
         S_COUNT: begin
            if (fs) begin
               snap_now = 1'b1;
               cnt_d    = '0;
               if (pix_hit) cnt_d[pix_cls] = CNT_W'(1);
            end else if (pix_hit) begin
               cnt_d[pix_cls] = sat_inc(cnt_q[pix_cls]);
            end
         end
      endcase

      // a snapshot wins over a transfer in the same cycle, keeping valid high
      if (snap_now) begin
         snap_d    = cnt_q;
         frame_d   = frm_cnt_q;
         frm_cnt_d = frm_cnt_q + 1'b1;
         valid_d   = 1'b1;
         ovr_d     = ovr_q | (valid_q & ~stat.stat_ready);
         led_d     = dominant(cnt_q[CLS_BLUE], cnt_q[CLS_YELLOW], cnt_q[CLS_BLACK]);
      end else if (valid_q & stat.stat_ready) begin
         valid_d   = 1'b0;
      end
   end

   // Stage 1: registered pass-through, counters and snapshot
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vid_q     <= '0;
         state_q   <= S_SYNC;
         cnt_q     <= '0;
         snap_q    <= '0;
         frm_cnt_q <= '0;
         frame_q   <= '0;
         valid_q   <= 1'b0;
         ovr_q     <= 1'b0;
         led_q     <= 3'b000;
      end else begin
         vid_q     <= vid_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         snap_q    <= snap_d;
         frm_cnt_q <= frm_cnt_d;
         frame_q   <= frame_d;
         valid_q   <= valid_d;
         ovr_q     <= ovr_d;
         led_q     <= led_d;
      end
   end

   assign vs_out           = vid_q.vs;
   assign hs_out           = vid_q.hs;
   assign de_out           = vid_q.de;
   assign r_out            = vid_q.r;
   assign g_out            = vid_q.g;
   assign b_out            = vid_q.b;

   assign stat.stat_blue   = snap_q[CLS_BLUE];
   assign stat.stat_yellow = snap_q[CLS_YELLOW];
   assign stat.stat_black  = snap_q[CLS_BLACK];
   assign stat.stat_other  = snap_q[CLS_OTHER];
   assign stat.stat_frame  = frame_q;
   assign stat.stat_valid  = valid_q;
   assign stat.stat_ovr    = ovr_q;
   assign led              = led_q;

endmodule

// File: tb/tb_snn_frame_stats.sv
// Self-checking bench for snn_frame_stats: a full-width instance and a 4-bit
// counter instance share the same video and ready stimulus.
module tb_snn_frame_stats;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
   logic [7:0]  r_in = '0, g_in = '0, b_in = '0;
   logic        ready = 1'b0;

   logic        vs_out, hs_out, de_out;
   logic [7:0]  r_out, g_out, b_out;
   logic [2:0]  led;
   logic        vs_o4, hs_o4, de_o4;
   logic [7:0]  r_o4, g_o4, b_o4;
   logic [2:0]  led4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   snn_frame_stats_if #(.CNT_W(24), .FRM_W(16)) st ();
   snn_frame_stats_if #(.CNT_W(4),  .FRM_W(16)) st4 ();
   assign st.stat_ready  = ready;
   assign st4.stat_ready = ready;

   snn_frame_stats #(.CNT_W(24), .FRM_W(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
      .r_out(r_out), .g_out(g_out), .b_out(b_out),
      .stat(st), .led(led)
   );

   snn_frame_stats #(.CNT_W(4), .FRM_W(16)) dut4 (
      .clk(clk), .reset_n(reset_n),
      .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .vs_out(vs_o4), .hs_out(hs_o4), .de_out(de_o4),
      .r_out(r_o4), .g_out(g_o4), .b_out(b_o4),
      .stat(st4), .led(led4)
   );

   // ---------------- reference model ----------------
   // Keeps the list of counted pixel classes of the current frame and
   // evaluates a frame's statistics only when it completes.
   bit          m_sync;
   bit          m_prev_vs;
   int          m_frame_idx;
   int          m_q[$];
   logic [23:0] e_blue, e_yel, e_blk, e_oth;
   logic [3:0]  e4_blue, e4_yel, e4_blk, e4_oth;
   logic [15:0] e_frame;
   logic        e_valid, e_ovr;
   logic [2:0]  e_led;
   logic [23:0] frame_pix[$];

   function automatic int cls_of(input logic [23:0] p);
      if (p == 24'h0000FF) return 0;
      if (p == 24'hFFFF00) return 1;
      if (p == 24'h000000) return 2;
      return 3;
   endfunction

   function automatic logic [23:0] rand_pix();
      case ($urandom_range(0, 4))
         0: return 24'h0000FF;
         1: return 24'hFFFF00;
         2: return 24'h000000;
         3: return {8'd10, 8'd20, 8'd30};
         default: return 24'($urandom);
      endcase
   endfunction

   task automatic model_step();
      int n[4];
      if (!reset_n) begin
         m_sync = 0; m_prev_vs = 0; m_frame_idx = 0; m_q.delete();
         e_blue = '0; e_yel = '0; e_blk = '0; e_oth = '0;
         e4_blue = '0; e4_yel = '0; e4_blk = '0; e4_oth = '0;
         e_frame = '0; e_valid = 0; e_ovr = 0; e_led = '0;
         return;
      end
      if (vs_in && !m_prev_vs) begin
         if (m_sync) begin
            n = '{0, 0, 0, 0};
            foreach (m_q[i]) n[m_q[i]]++;
            e_blue = 24'(n[0]); e_yel = 24'(n[1]); e_blk = 24'(n[2]); e_oth = 24'(n[3]);
            e4_blue = 4'((n[0] > 15) ? 15 : n[0]);
            e4_yel  = 4'((n[1] > 15) ? 15 : n[1]);
            e4_blk  = 4'((n[2] > 15) ? 15 : n[2]);
            e4_oth  = 4'((n[3] > 15) ? 15 : n[3]);
            if (n[0] == 0 && n[1] == 0 && n[2] == 0) e_led = 3'b001;
            else if (n[0] >= n[1] && n[0] >= n[2])   e_led = 3'b100;
            else if (n[1] >= n[2])                   e_led = 3'b010;
            else                                     e_led = 3'b001;
            e_frame = 16'(m_frame_idx % 65536);
            m_frame_idx++;
            e_ovr   = e_ovr | (e_valid & !ready);
            e_valid = 1;
         end
         m_sync = 1;
         m_q.delete();
         if (de_in) m_q.push_back(cls_of({r_in, g_in, b_in}));
      end else begin
         if (e_valid && ready) e_valid = 0;
         if (m_sync && de_in) m_q.push_back(cls_of({r_in, g_in, b_in}));
      end
      m_prev_vs = vs_in;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input logic vs, input logic hs, input logic de, input logic [23:0] rgb);
      vs_in = vs; hs_in = hs; de_in = de; {r_in, g_in, b_in} = rgb;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic fs_pulse();
      cyc(1'b0, 1'b0, 1'b0, 24'h0);
      cyc(1'b1, 1'b0, 1'b0, 24'h0);
   endtask

   task automatic send_body(input int w);
      cyc(1'b0, 1'b0, 1'b0, 24'h0);
      for (int i = 0; i < frame_pix.size(); i++) begin
         cyc(1'b0, 1'b0, 1'b1, frame_pix[i]);
         if ((i + 1) % w == 0) cyc(1'b0, 1'b1, 1'b0, 24'h0);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 24'h0);
      cyc(1'b0, 1'b0, 1'b0, 24'h0);
      reset_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [23:0] px;
      ready = 1'b1;
      do_reset();
      checks++;
      if ({vs_out, hs_out, de_out, r_out, g_out, b_out, st.stat_blue, st.stat_yellow,
           st.stat_black, st.stat_other, st.stat_frame, st.stat_valid, st.stat_ovr, led} !== '0) begin
         errors++;
         $display("FAIL reset_state: outputs not all zero (valid=%b led=%b vs_out=%b)",
                  st.stat_valid, led, vs_out);
      end
      // reset lands in the middle of a frame at pixel 50
      fs_pulse();
      for (int i = 0; i < 60; i++) begin
         if (i == 50) reset_n = 1'b0;
         if (i == 52) reset_n = 1'b1;
         px = rand_pix();
         cyc(1'b0, 1'b0, 1'b1, px);
         if (i == 51) begin
            checks++;
            if ({vs_out, hs_out, de_out, r_out, g_out, b_out, st.stat_valid, st.stat_ovr, led,
                 st.stat_blue, st.stat_frame} !== '0) begin
               errors++;
               $display("FAIL reset_midframe: outputs during reset de_out=%b rgb=%h valid=%b want 0",
                        de_out, {r_out, g_out, b_out}, st.stat_valid);
            end
         end
      end
      fs_pulse();
      checks++;
      if (st.stat_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_fs: stat_valid=%b want 0", st.stat_valid);
      end
      frame_pix.delete();
      for (int i = 0; i < 8; i++) frame_pix.push_back(rand_pix());
      send_body(4);
      fs_pulse();
      checks++;
      if ({st.stat_valid, st.stat_frame, st.stat_blue, st.stat_yellow, st.stat_black, st.stat_other}
          !== {1'b1, 16'd0, e_blue, e_yel, e_blk, e_oth}) begin
         errors++;
         $display("FAIL reset_second_fs: valid=%b frame=%0d b/y/k/o=%0d/%0d/%0d/%0d want valid=1 frame=0 %0d/%0d/%0d/%0d",
                  st.stat_valid, st.stat_frame, st.stat_blue, st.stat_yellow, st.stat_black,
                  st.stat_other, e_blue, e_yel, e_blk, e_oth);
      end
   endtask

   task automatic test_tiny_frame();
      ready = 1'b1;
      do_reset();
      frame_pix = '{24'h0000FF, 24'hFFFF00, 24'h0000FF, 24'h000000,
                    24'h0000FF, 24'h0000FF, 24'hFFFF00, 24'h0000FF};
      fs_pulse();
      send_body(4);
      fs_pulse();
      checks++;
      if (st.stat_blue !== 24'd5) begin errors++; $display("FAIL tiny_blue: got %0d want 5", st.stat_blue); end
      checks++;
      if (st.stat_yellow !== 24'd2) begin errors++; $display("FAIL tiny_yellow: got %0d want 2", st.stat_yellow); end
      checks++;
      if (st.stat_black !== 24'd1) begin errors++; $display("FAIL tiny_black: got %0d want 1", st.stat_black); end
      checks++;
      if (st.stat_other !== 24'd0) begin errors++; $display("FAIL tiny_other: got %0d want 0", st.stat_other); end
      checks++;
      if (st.stat_frame !== 16'd0) begin errors++; $display("FAIL tiny_frame_idx: got %0d want 0", st.stat_frame); end
      checks++;
      if (st.stat_valid !== 1'b1) begin errors++; $display("FAIL tiny_valid: got %b want 1", st.stat_valid); end
      checks++;
      if (led !== 3'b100) begin errors++; $display("FAIL tiny_led: got %b want 100", led); end
   endtask

   task automatic test_latency();
      logic        v;
      logic        h, d;
      logic [23:0] px;
      v = vs_in;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 24) == 0) v = ~v;
         h = ($urandom_range(0, 9) == 0);
         d = ($urandom_range(0, 3) != 0);
         px = rand_pix();
         ready = 1'($urandom_range(0, 1));
         cyc(v, h, d, px);
         checks++;
         if ({vs_out, hs_out, de_out, r_out, g_out, b_out} !== {v, h, d, px}) begin
            errors++;
            $display("FAIL latency cycle %0d: out=%b%b%b %h want %b%b%b %h", i,
                     vs_out, hs_out, de_out, {r_out, g_out, b_out}, v, h, d, px);
         end
         checks++;
         if ({st.stat_blue, st.stat_yellow, st.stat_black, st.stat_other, st.stat_frame,
              st.stat_valid, st.stat_ovr, led} !==
             {e_blue, e_yel, e_blk, e_oth, e_frame, e_valid, e_ovr, e_led}) begin
            errors++;
            $display("FAIL random_stats cycle %0d: b/y/k/o=%0d/%0d/%0d/%0d f=%0d v=%b o=%b led=%b want %0d/%0d/%0d/%0d f=%0d v=%b o=%b led=%b",
                     i, st.stat_blue, st.stat_yellow, st.stat_black, st.stat_other, st.stat_frame,
                     st.stat_valid, st.stat_ovr, led, e_blue, e_yel, e_blk, e_oth, e_frame,
                     e_valid, e_ovr, e_led);
         end
         checks++;
         if ({st4.stat_blue, st4.stat_yellow, st4.stat_black, st4.stat_other, st4.stat_valid} !==
             {e4_blue, e4_yel, e4_blk, e4_oth, e_valid}) begin
            errors++;
            $display("FAIL random_stats_sat cycle %0d: b/y/k/o=%0d/%0d/%0d/%0d v=%b want %0d/%0d/%0d/%0d v=%b",
                     i, st4.stat_blue, st4.stat_yellow, st4.stat_black, st4.stat_other,
                     st4.stat_valid, e4_blue, e4_yel, e4_blk, e4_oth, e_valid);
         end
      end
   endtask

   task automatic test_tie_other();
      ready = 1'b1;
      do_reset();
      frame_pix = '{24'hFFFF00, 24'h000000, {8'd10, 8'd20, 8'd30}, 24'hFFFF00,
                    24'h000000, 24'hFFFF00, {8'd10, 8'd20, 8'd30}, 24'h000000};
      fs_pulse();
      send_body(4);
      fs_pulse();
      checks++;
      if (led !== 3'b010) begin errors++; $display("FAIL tie_led: got %b want 010", led); end
      checks++;
      if (st.stat_other !== 24'd2) begin errors++; $display("FAIL tie_other: got %0d want 2", st.stat_other); end
      checks++;
      if ({st.stat_blue, st.stat_yellow, st.stat_black} !== {24'd0, 24'd3, 24'd3}) begin
         errors++;
         $display("FAIL tie_counts: b/y/k=%0d/%0d/%0d want 0/3/3", st.stat_blue, st.stat_yellow, st.stat_black);
      end
   endtask

   task automatic test_backpressure();
      ready = 1'b1;
      do_reset();
      ready = 1'b0;
      frame_pix.delete();
      for (int i = 0; i < 8; i++) frame_pix.push_back(rand_pix());
      fs_pulse();
      send_body(4);
      fs_pulse();
      checks++;
      if ({st.stat_valid, st.stat_ovr} !== 2'b10) begin
         errors++;
         $display("FAIL bp_first_snapshot: valid=%b ovr=%b want valid=1 ovr=0", st.stat_valid, st.stat_ovr);
      end
      frame_pix.delete();
      for (int i = 0; i < 6; i++) frame_pix.push_back(24'h0000FF);
      send_body(3);
      fs_pulse();
      checks++;
      if ({st.stat_valid, st.stat_ovr, st.stat_frame, st.stat_blue} !== {1'b1, 1'b1, 16'd1, 24'd6}) begin
         errors++;
         $display("FAIL bp_overwrite: valid=%b ovr=%b frame=%0d blue=%0d want 1 1 1 6",
                  st.stat_valid, st.stat_ovr, st.stat_frame, st.stat_blue);
      end
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 24'h0);
         checks++;
         if ({st.stat_valid, st.stat_ovr, st.stat_blue} !== {1'b1, 1'b1, 24'd6}) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: valid=%b ovr=%b blue=%0d want 1 1 6",
                     i, st.stat_valid, st.stat_ovr, st.stat_blue);
         end
      end
      ready = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 24'h0);
      checks++;
      if ({st.stat_valid, st.stat_ovr} !== 2'b01) begin
         errors++;
         $display("FAIL bp_release: valid=%b ovr=%b want valid=0 ovr=1", st.stat_valid, st.stat_ovr);
      end
   endtask

   task automatic test_back_to_back();
      ready = 1'b1;
      do_reset();
      ready = 1'b0;
      frame_pix = '{24'h000000, 24'h000000};
      fs_pulse();
      send_body(2);
      fs_pulse();
      frame_pix = '{24'hFFFF00, 24'h000000, 24'hFFFF00};
      send_body(3);
      cyc(1'b0, 1'b0, 1'b0, 24'h0);
      // fs and transfer coincide on this edge
      ready = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 24'h0);
      checks++;
      if ({st.stat_valid, st.stat_ovr, st.stat_frame, st.stat_yellow, led} !==
          {1'b1, 1'b0, 16'd1, 24'd2, 3'b010}) begin
         errors++;
         $display("FAIL b2b_coincident: valid=%b ovr=%b frame=%0d yellow=%0d led=%b want 1 0 1 2 010",
                  st.stat_valid, st.stat_ovr, st.stat_frame, st.stat_yellow, led);
      end
      cyc(1'b0, 1'b0, 1'b0, 24'h0);
      checks++;
      if ({st.stat_valid, st.stat_ovr} !== 2'b00) begin
         errors++;
         $display("FAIL b2b_drain: valid=%b ovr=%b want 0 0", st.stat_valid, st.stat_ovr);
      end
   endtask

   task automatic test_saturation();
      ready = 1'b1;
      do_reset();
      frame_pix.delete();
      for (int i = 0; i < 20; i++) frame_pix.push_back(24'h0000FF);
      fs_pulse();
      send_body(5);
      fs_pulse();
      checks++;
      if (st4.stat_blue !== 4'd15) begin
         errors++;
         $display("FAIL sat_blue_cnt4: got %0d want 15", st4.stat_blue);
      end
      checks++;
      if (st.stat_blue !== 24'd20) begin
         errors++;
         $display("FAIL sat_blue_cnt24: got %0d want 20", st.stat_blue);
      end
      checks++;
      if ({st4.stat_yellow, st4.stat_black, st4.stat_other, st4.stat_valid} !== {4'd0, 4'd0, 4'd0, 1'b1}) begin
         errors++;
         $display("FAIL sat_others_cnt4: y/k/o=%0d/%0d/%0d valid=%b want 0/0/0 1",
                  st4.stat_yellow, st4.stat_black, st4.stat_other, st4.stat_valid);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_tiny_frame();
      test_latency();
      test_tie_other();
      test_backpressure();
      test_back_to_back();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
